// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the test-SRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 16;
    localparam int SRAM_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_BUS  = 1'b0,
        PORT_CORE = 1'b1
    } port_t;

endpackage

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between the bus port and the cipher core.
// Latency: request seen in IDLE cycle c -> strobe c+1..c+SRAM_LAT, ack at c+SRAM_LAT+1.
// Backpressure: requests are level-held until ack; the loser waits for the next IDLE.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int DATA_W   = SRAM_DATA_W,
    parameter int SRAM_LAT = 2            // strobe cycles per access, 1..7
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic              bus_ack,
    output logic [DATA_W-1:0] bus_rdata,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ack,
    output logic [DATA_W-1:0] core_rdata,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              busy
);

    state_t            r_state;
    logic [2:0]        r_cnt;
    port_t             r_grant;
    port_t             r_last_grant;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_bus_rdata;
    logic [DATA_W-1:0] r_core_rdata;

    port_t             w_grant;

    // Winner selection: a lone requester wins; on a tie the port not served last wins.
    always_comb begin
        w_grant = PORT_BUS;
        if (bus_req && core_req) begin
            w_grant = (r_last_grant == PORT_CORE) ? PORT_BUS : PORT_CORE;
        end else if (core_req) begin
            w_grant = PORT_CORE;
        end
    end

    // Access sequencer: grant and latch in IDLE, count strobe cycles, one-cycle ack in DONE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_cnt        <= 3'd0;
            r_grant      <= PORT_BUS;
            r_last_grant <= PORT_CORE;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_bus_rdata  <= '0;
            r_core_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus_req || core_req) begin
                        r_grant <= w_grant;
                        r_cnt   <= 3'(SRAM_LAT);
                        r_state <= ACCESS;
                        if (w_grant == PORT_BUS) begin
                            r_we    <= bus_we;
                            r_addr  <= bus_addr;
                            r_wdata <= bus_wdata;
                        end else begin
                            r_we    <= core_we;
                            r_addr  <= core_addr;
                            r_wdata <= core_wdata;
                        end
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= DONE;
                        // Read data is taken at the end of the last strobe cycle.
                        if (!r_we) begin
                            if (r_grant == PORT_BUS) begin
                                r_bus_rdata <= read_data;
                            end else begin
                                r_core_rdata <= read_data;
                            end
                        end
                    end
                end
                DONE: begin
                    r_last_grant <= r_grant;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register so an async reset drops them at once.
    assign read       = (r_state == ACCESS) && !r_we;
    assign write      = (r_state == ACCESS) &&  r_we;
    assign addr       = r_addr;
    assign write_data = r_wdata;
    assign busy       = (r_state != IDLE);
    assign bus_ack    = (r_state == DONE) && (r_grant == PORT_BUS);
    assign core_ack   = (r_state == DONE) && (r_grant == PORT_CORE);
    assign bus_rdata  = r_bus_rdata;
    assign core_rdata = r_core_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default build (SRAM_LAT=2) and a SRAM_LAT=1 build.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic n_rst = 1'b0;

    always #5 clk = ~clk;

    // Default build (SRAM_LAT = 2)
    logic         bus_req = 0, bus_we = 0, core_req = 0, core_we = 0;
    logic [15:0]  bus_addr = 0, core_addr = 0;
    logic [127:0] bus_wdata = 0, core_wdata = 0;
    logic         bus_ack, core_ack, rd, wr, busy;
    logic [127:0] bus_rdata, core_rdata, wdat, rdat;
    logic [15:0]  sa;

    // SRAM_LAT = 1 build
    logic         bus_req1 = 0, bus_we1 = 0, core_req1 = 0, core_we1 = 0;
    logic [15:0]  bus_addr1 = 0, core_addr1 = 0;
    logic [127:0] bus_wdata1 = 0, core_wdata1 = 0;
    logic         bus_ack1, core_ack1, rd1, wr1, busy1;
    logic [127:0] bus_rdata1, core_rdata1, wdat1, rdat1;
    logic [15:0]  sa1;

    int checks = 0;
    int failures = 0;

    // SRAM model: combinational read, write committed only on the last cycle of a full strobe.
    logic [127:0] mem [0:255];
    int wcnt = 0;

    function automatic logic [127:0] init_word(input logic [7:0] a);
        return {8{a, 8'hA5}};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(8'(i));
    end

    assign rdat  = mem[sa[7:0]];
    assign rdat1 = mem[sa1[7:0]];

    always @(posedge clk) begin
        if (wr) begin
            if (wcnt == 1) mem[sa[7:0]] = wdat;
            wcnt = wcnt + 1;
        end else begin
            wcnt = 0;
        end
    end

    sram_arbiter u_dut (
        .clk(clk), .n_rst(n_rst),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ack(core_ack), .core_rdata(core_rdata),
        .read(rd), .write(wr), .addr(sa), .write_data(wdat), .read_data(rdat), .busy(busy)
    );

    sram_arbiter #(.SRAM_LAT(1)) u_dut1 (
        .clk(clk), .n_rst(n_rst),
        .bus_req(bus_req1), .bus_we(bus_we1), .bus_addr(bus_addr1), .bus_wdata(bus_wdata1),
        .bus_ack(bus_ack1), .bus_rdata(bus_rdata1),
        .core_req(core_req1), .core_we(core_we1), .core_addr(core_addr1), .core_wdata(core_wdata1),
        .core_ack(core_ack1), .core_rdata(core_rdata1),
        .read(rd1), .write(wr1), .addr(sa1), .write_data(wdat1), .read_data(rdat1), .busy(busy1)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus_req = 1; bus_we = 0; bus_addr = 16'h0005;
        core_req = 1; core_we = 0; core_addr = 16'h0006;
        repeat (3) step();
        checks++;
        if ({rd, wr, busy, bus_ack, core_ack} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl got rd/wr/busy/back/cack=%b want 00000", {rd, wr, busy, bus_ack, core_ack});
        end
        checks++;
        if (sa !== 16'h0 || wdat !== 128'h0 || bus_rdata !== 128'h0 || core_rdata !== 128'h0) begin
            failures++; $display("FAIL reset_data got addr=%h wdata=%h brd=%h crd=%h want all 0", sa, wdat, bus_rdata, core_rdata);
        end
        n_rst = 1;
        step();
        checks++;
        if (sa !== 16'h0005 || rd !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL reset_first_grant got addr=%h rd=%b busy=%b want addr=0005 rd=1 busy=1", sa, rd, busy);
        end
        bus_req = 0; core_req = 0;
        step(); step();
        checks++;
        if (bus_ack !== 1'b1 || core_ack !== 1'b0 || bus_rdata !== init_word(8'h05)) begin
            failures++; $display("FAIL reset_first_ack got back=%b cack=%b rdata=%h want 1 0 %h", bus_ack, core_ack, bus_rdata, init_word(8'h05));
        end
        step();
    endtask

    task automatic test_bus_write_read();
        logic [127:0] d;
        d = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        bus_req = 1; bus_we = 1; bus_addr = 16'h0010; bus_wdata = d;
        step();
        checks++;
        if (wr !== 1'b1 || rd !== 1'b0 || sa !== 16'h0010 || wdat !== d || bus_ack !== 1'b0) begin
            failures++; $display("FAIL wr_cycle1 got wr=%b rd=%b addr=%h wdata=%h ack=%b", wr, rd, sa, wdat, bus_ack);
        end
        step();
        checks++;
        if (wr !== 1'b1 || bus_ack !== 1'b0) begin
            failures++; $display("FAIL wr_cycle2 got wr=%b ack=%b want 1 0", wr, bus_ack);
        end
        step();
        checks++;
        if (wr !== 1'b0 || bus_ack !== 1'b1 || core_ack !== 1'b0) begin
            failures++; $display("FAIL wr_ack got wr=%b back=%b cack=%b want 0 1 0", wr, bus_ack, core_ack);
        end
        bus_req = 0;
        step();
        checks++;
        if (busy !== 1'b0 || bus_ack !== 1'b0 || wdat !== d) begin
            failures++; $display("FAIL wr_idle got busy=%b ack=%b wdata=%h want 0 0 held", busy, bus_ack, wdat);
        end
        bus_req = 1; bus_we = 0; bus_wdata = '0;
        step();
        checks++;
        if (rd !== 1'b1 || wr !== 1'b0 || sa !== 16'h0010) begin
            failures++; $display("FAIL rd_strobe got rd=%b wr=%b addr=%h want 1 0 0010", rd, wr, sa);
        end
        step(); step();
        checks++;
        if (bus_ack !== 1'b1 || bus_rdata !== d || core_ack !== 1'b0) begin
            failures++; $display("FAIL rd_data got ack=%b rdata=%h cack=%b want 1 %h 0", bus_ack, bus_rdata, core_ack, d);
        end
        bus_req = 0;
        step();
    endtask

    task automatic test_late_arrival();
        bus_req = 1; bus_we = 0; bus_addr = 16'h0020;
        step(); step();
        core_req = 1; core_we = 0; core_addr = 16'h0030;
        checks++;
        if (sa !== 16'h0020 || rd !== 1'b1) begin
            failures++; $display("FAIL late_bus_strobe got addr=%h rd=%b want 0020 1", sa, rd);
        end
        step();
        checks++;
        if (bus_ack !== 1'b1 || core_ack !== 1'b0 || bus_rdata !== init_word(8'h20)) begin
            failures++; $display("FAIL late_bus_ack got back=%b cack=%b rdata=%h want 1 0 %h", bus_ack, core_ack, bus_rdata, init_word(8'h20));
        end
        bus_req = 0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL late_idle got busy=%b want 0", busy);
        end
        step();
        checks++;
        if (sa !== 16'h0030 || rd !== 1'b1) begin
            failures++; $display("FAIL late_core_grant got addr=%h rd=%b want 0030 1", sa, rd);
        end
        step(); step();
        checks++;
        if (core_ack !== 1'b1 || bus_ack !== 1'b0 || core_rdata !== init_word(8'h30) || bus_rdata !== init_word(8'h20)) begin
            failures++; $display("FAIL late_core_ack got cack=%b back=%b crd=%h brd=%h", core_ack, bus_ack, core_rdata, bus_rdata);
        end
        core_req = 0;
        step();
    endtask

    task automatic test_contention();
        logic        exp_core;
        logic [15:0] exp_a;
        bus_req = 1; bus_we = 0; bus_addr = 16'h0001;
        core_req = 1; core_we = 0; core_addr = 16'h0002;
        for (int k = 0; k < 4; k++) begin
            exp_core = (k % 2) == 1;
            exp_a = exp_core ? 16'h0002 : 16'h0001;
            step();
            checks++;
            if (sa !== exp_a || rd !== 1'b1) begin
                failures++; $display("FAIL cont_grant k=%0d got addr=%h rd=%b want %h 1", k, sa, rd, exp_a);
            end
            step(); step();
            checks++;
            if (bus_ack !== !exp_core || core_ack !== exp_core ||
                (exp_core ? core_rdata : bus_rdata) !== init_word(exp_a[7:0])) begin
                failures++; $display("FAIL cont_ack k=%0d got back=%b cack=%b want %b %b", k, bus_ack, core_ack, !exp_core, exp_core);
            end
            step();
            checks++;
            if (busy !== 1'b0 || bus_ack !== 1'b0 || core_ack !== 1'b0) begin
                failures++; $display("FAIL cont_idle k=%0d got busy=%b back=%b cack=%b want 0 0 0", k, busy, bus_ack, core_ack);
            end
        end
        bus_req = 0; core_req = 0;
        step();
    endtask

    task automatic test_reset_mid_access();
        core_req = 1; core_we = 1; core_addr = 16'h00FF; core_wdata = {4{32'hDEADBEEF}};
        step();
        checks++;
        if (wr !== 1'b1 || sa !== 16'h00FF) begin
            failures++; $display("FAIL abort_strobe got wr=%b addr=%h want 1 00ff", wr, sa);
        end
        n_rst = 0;
        #1;
        checks++;
        if (wr !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_drop got wr=%b busy=%b want 0 0", wr, busy);
        end
        core_req = 0;
        step(); step();
        checks++;
        if (core_ack !== 1'b0 || bus_ack !== 1'b0) begin
            failures++; $display("FAIL abort_noack got cack=%b back=%b want 0 0", core_ack, bus_ack);
        end
        n_rst = 1;
        step();
        checks++;
        if (busy !== 1'b0 || mem[8'hFF] !== init_word(8'hFF)) begin
            failures++; $display("FAIL abort_after got busy=%b mem=%h want 0 %h", busy, mem[8'hFF], init_word(8'hFF));
        end
    endtask

    task automatic test_lat1();
        bus_req1 = 1; bus_we1 = 0; bus_addr1 = 16'h0040;
        step();
        checks++;
        if (rd1 !== 1'b1 || sa1 !== 16'h0040 || bus_ack1 !== 1'b0) begin
            failures++; $display("FAIL lat1_strobe got rd=%b addr=%h ack=%b want 1 0040 0", rd1, sa1, bus_ack1);
        end
        step();
        checks++;
        if (rd1 !== 1'b0 || bus_ack1 !== 1'b1 || bus_rdata1 !== init_word(8'h40)) begin
            failures++; $display("FAIL lat1_ack got rd=%b ack=%b rdata=%h want 0 1 %h", rd1, bus_ack1, bus_rdata1, init_word(8'h40));
        end
        bus_req1 = 0;
        step();
        checks++;
        if (busy1 !== 1'b0 || bus_ack1 !== 1'b0) begin
            failures++; $display("FAIL lat1_idle got busy=%b ack=%b want 0 0", busy1, bus_ack1);
        end
    endtask

    initial begin
        step();
        test_reset();
        test_bus_write_read();
        test_late_arrival();
        test_contention();
        test_reset_mid_access();
        test_lat1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
